// File: rtl/usb_rx_buffer_if.sv
// Handshake bundle between the USB receiver/AHB consumer and the packet receive buffer.
// The buffer itself uses the slave modport; the driving side uses master.
interface usb_rx_buffer_if #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
);
  logic [2:0]  rx_packet;
  logic [7:0]  rx_packet_data;
  logic        store_rx_packet_data;
  logic        get_rx_data;
  logic        flush;
  logic [7:0]  rx_data;
  logic [AW:0] buffer_occupancy;
  logic        buffer_empty;
  logic        buffer_full;
  logic        overflow_err;
  logic        underflow_err;

  modport master (
    output rx_packet, rx_packet_data, store_rx_packet_data, get_rx_data, flush,
    input  rx_data, buffer_occupancy, buffer_empty, buffer_full, overflow_err, underflow_err
  );

  modport slave (
    input  rx_packet, rx_packet_data, store_rx_packet_data, get_rx_data, flush,
    output rx_data, buffer_occupancy, buffer_empty, buffer_full, overflow_err, underflow_err
  );
endinterface

// File: rtl/usb_rx_buffer.sv
// Packet-granular receive FIFO: bytes stay tentative until the receiver signals DONE,
// and a failed or overflowed packet is rolled back to the last commit point.
module usb_rx_buffer #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  usb_rx_buffer_if.slave bus
);
  localparam logic [2:0]  PKT_DONE  = 3'b101;
  localparam logic [2:0]  PKT_ERR   = 3'b110;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, cm_ptr, rd_ptr;
  logic [AW:0] wr_next, cm_next, rd_next;
  logic        pkt_bad, pkt_bad_next;
  logic [2:0]  rx_packet_q;
  logic        overflow_err, underflow_err;
  logic        done_evt, err_evt;
  logic        full, empty;
  logic        do_store, drop, do_pop;

  assign done_evt = (bus.rx_packet == PKT_DONE) && (rx_packet_q != PKT_DONE);
  assign err_evt  = (bus.rx_packet == PKT_ERR)  && (rx_packet_q != PKT_ERR);

  // Full counts tentative bytes too, measured against the reader so a pop frees space
  assign full     = (wr_ptr - rd_ptr) == DEPTH_CNT;
  assign empty    = (cm_ptr == rd_ptr);
  assign do_store = bus.store_rx_packet_data && !full;
  assign drop     = bus.store_rx_packet_data && full;
  assign do_pop   = bus.get_rx_data && !empty;

  always_comb begin
    wr_next      = wr_ptr + {{AW{1'b0}}, do_store};
    cm_next      = cm_ptr;
    rd_next      = rd_ptr + {{AW{1'b0}}, do_pop};
    pkt_bad_next = pkt_bad | drop;
    if (err_evt || (done_evt && pkt_bad_next)) begin
      wr_next      = cm_ptr;
      pkt_bad_next = 1'b0;
    end else if (done_evt) begin
      cm_next      = wr_next;
      pkt_bad_next = 1'b0;
    end
  end

  // Flush leaves the edge detector running so a held DONE/ERR cannot retrigger afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      cm_ptr        <= '0;
      rd_ptr        <= '0;
      pkt_bad       <= 1'b0;
      rx_packet_q   <= 3'b000;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      rx_packet_q <= bus.rx_packet;
      if (bus.flush) begin
        wr_ptr        <= '0;
        cm_ptr        <= '0;
        rd_ptr        <= '0;
        pkt_bad       <= 1'b0;
        overflow_err  <= 1'b0;
        underflow_err <= 1'b0;
      end else begin
        wr_ptr  <= wr_next;
        cm_ptr  <= cm_next;
        rd_ptr  <= rd_next;
        pkt_bad <= pkt_bad_next;
        if (drop)
          overflow_err <= 1'b1;
        if (bus.get_rx_data && empty)
          underflow_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_store)
      mem[wr_ptr[AW-1:0]] <= bus.rx_packet_data;
  end

  assign bus.rx_data          = mem[rd_ptr[AW-1:0]];
  assign bus.buffer_occupancy = cm_ptr - rd_ptr;
  assign bus.buffer_empty     = empty;
  assign bus.buffer_full      = full;
  assign bus.overflow_err     = overflow_err;
  assign bus.underflow_err    = underflow_err;
endmodule

// File: tb/tb_usb_rx_buffer.sv
// Scoreboard bench for usb_rx_buffer: committed bytes are queued as expected data
// and a negedge monitor compares every byte the DUT hands out on a pop.
module tb_usb_rx_buffer;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst;

  usb_rx_buffer_if #(.DEPTH(DEPTH)) bus ();

  usb_rx_buffer #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  int checks  = 0;
  int passes  = 0;
  int max_occ = 0;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected)
      passes++;
    else
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic apply_stimulus(input logic st, input logic [7:0] d, input logic pp,
                                input logic [2:0] pk, input logic fl);
    bus.store_rx_packet_data = st;
    bus.rx_packet_data       = d;
    bus.get_rx_data          = pp;
    bus.rx_packet            = pk;
    bus.flush                = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic store_bytes(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++)
      apply_stimulus(1'b1, first + 8'(i), 1'b0, 3'b000, 1'b0);
  endtask

  task automatic expect_bytes(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back(first + 8'(i));
  endtask

  task automatic pop_bytes(input int n);
    for (int i = 0; i < n; i++)
      apply_stimulus(1'b0, 8'h00, 1'b1, 3'b000, 1'b0);
  endtask

  // Monitor: every accepted pop must hand out the oldest expected byte
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.get_rx_data === 1'b1 && bus.buffer_empty === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("[TB] FAIL rx_unexpected: got byte %0d, expected no data", bus.rx_data);
      end else begin
        check_output("rx_data", int'(bus.rx_data), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    rst = 1'b1;
    bus.store_rx_packet_data = 1'b0;
    bus.rx_packet_data       = 8'h00;
    bus.get_rx_data          = 1'b0;
    bus.rx_packet            = 3'b000;
    bus.flush                = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check_output("reset_occupancy", int'(bus.buffer_occupancy), 0);
    check_output("reset_empty", int'(bus.buffer_empty), 1);
    check_output("reset_full", int'(bus.buffer_full), 0);
    check_output("reset_overflow", int'(bus.overflow_err), 0);
    check_output("reset_underflow", int'(bus.underflow_err), 0);

    // Basic commit, with DONE held for two cycles
    apply_stimulus(1'b1, 8'hA5, 1'b0, 3'b000, 1'b0);
    apply_stimulus(1'b1, 8'h3C, 1'b0, 3'b000, 1'b0);
    apply_stimulus(1'b1, 8'h0F, 1'b0, 3'b000, 1'b0);
    check_output("commit_pre_done_occ", int'(bus.buffer_occupancy), 0);
    check_output("commit_pre_done_empty", int'(bus.buffer_empty), 1);
    apply_stimulus(1'b0, 8'h00, 1'b0, 3'b101, 1'b0);
    check_output("commit_occ", int'(bus.buffer_occupancy), 3);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h0F);
    apply_stimulus(1'b0, 8'h00, 1'b0, 3'b101, 1'b0);
    check_output("commit_held_done_occ", int'(bus.buffer_occupancy), 3);
    apply_stimulus(1'b0, 8'h00, 1'b0, 3'b000, 1'b0);
    pop_bytes(3);
    check_output("commit_drained_empty", int'(bus.buffer_empty), 1);
    check_output("commit_drained_occ", int'(bus.buffer_occupancy), 0);

    // Discard on ERR, then a good 2-byte packet
    store_bytes(8'h11, 4);
    apply_stimulus(1'b0, 8'h00, 1'b0, 3'b110, 1'b0);
    check_output("discard_occ", int'(bus.buffer_occupancy), 0);
    check_output("discard_full", int'(bus.buffer_full), 0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 3'b000, 1'b0);
    store_bytes(8'h55, 2);
    apply_stimulus(1'b0, 8'h00, 1'b0, 3'b101, 1'b0);
    check_output("discard_next_occ", int'(bus.buffer_occupancy), 2);
    expect_bytes(8'h55, 2);
    apply_stimulus(1'b0, 8'h00, 1'b0, 3'b000, 1'b0);
    pop_bytes(2);
    check_output("discard_next_empty", int'(bus.buffer_empty), 1);

    // Overflow: 65 stores into a 64-byte buffer, packet must be dropped on DONE
    store_bytes(8'h00, 64);
    check_output("overflow_full_at_64", int'(bus.buffer_full), 1);
    check_output("overflow_flag_before_drop", int'(bus.overflow_err), 0);
    store_bytes(8'h40, 1);
    check_output("overflow_flag", int'(bus.overflow_err), 1);
    check_output("overflow_occ_tentative", int'(bus.buffer_occupancy), 0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 3'b101, 1'b0);
    check_output("overflow_done_occ", int'(bus.buffer_occupancy), 0);
    check_output("overflow_done_full", int'(bus.buffer_full), 0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 3'b000, 1'b0);
    store_bytes(8'hC0, 10);
    apply_stimulus(1'b0, 8'h00, 1'b0, 3'b101, 1'b0);
    check_output("overflow_next_occ", int'(bus.buffer_occupancy), 10);
    expect_bytes(8'hC0, 10);
    apply_stimulus(1'b0, 8'h00, 1'b0, 3'b000, 1'b0);
    pop_bytes(10);
    check_output("overflow_next_empty", int'(bus.buffer_empty), 1);
    check_output("overflow_sticky", int'(bus.overflow_err), 1);

    // Wrap: three 48-byte packets, each stored while the previous one drains
    max_occ = 0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 48; i++) begin
        apply_stimulus(1'b1, 8'(r * 48 + i), (r > 0), 3'b000, 1'b0);
        if (int'(bus.buffer_occupancy) > max_occ) max_occ = int'(bus.buffer_occupancy);
      end
      apply_stimulus(1'b0, 8'h00, 1'b0, 3'b101, 1'b0);
      if (int'(bus.buffer_occupancy) > max_occ) max_occ = int'(bus.buffer_occupancy);
      check_output("wrap_commit_occ", int'(bus.buffer_occupancy), 48);
      expect_bytes(8'(r * 48), 48);
      apply_stimulus(1'b0, 8'h00, 1'b0, 3'b000, 1'b0);
    end
    for (int i = 0; i < 48; i++) begin
      apply_stimulus(1'b0, 8'h00, 1'b1, 3'b000, 1'b0);
      if (int'(bus.buffer_occupancy) > max_occ) max_occ = int'(bus.buffer_occupancy);
    end
    check_output("wrap_max_occ", max_occ, 48);
    check_output("wrap_drained_empty", int'(bus.buffer_empty), 1);
    check_output("wrap_no_underflow", int'(bus.underflow_err), 0);

    // Underflow leaves pointers alone; flush clears contents and both flags
    apply_stimulus(1'b0, 8'h00, 1'b1, 3'b000, 1'b0);
    check_output("underflow_flag", int'(bus.underflow_err), 1);
    check_output("underflow_occ", int'(bus.buffer_occupancy), 0);
    store_bytes(8'h77, 1);
    apply_stimulus(1'b0, 8'h00, 1'b0, 3'b101, 1'b0);
    check_output("underflow_next_occ", int'(bus.buffer_occupancy), 1);
    expect_bytes(8'h77, 1);
    apply_stimulus(1'b0, 8'h00, 1'b0, 3'b000, 1'b0);
    pop_bytes(1);
    store_bytes(8'h90, 5);
    apply_stimulus(1'b0, 8'h00, 1'b0, 3'b101, 1'b0);
    check_output("flush_pre_occ", int'(bus.buffer_occupancy), 5);
    apply_stimulus(1'b0, 8'h00, 1'b0, 3'b000, 1'b1);
    check_output("flush_occ", int'(bus.buffer_occupancy), 0);
    check_output("flush_empty", int'(bus.buffer_empty), 1);
    check_output("flush_overflow", int'(bus.overflow_err), 0);
    check_output("flush_underflow", int'(bus.underflow_err), 0);
    store_bytes(8'hE1, 2);
    apply_stimulus(1'b0, 8'h00, 1'b0, 3'b101, 1'b0);
    check_output("flush_next_occ", int'(bus.buffer_occupancy), 2);
    expect_bytes(8'hE1, 2);
    apply_stimulus(1'b0, 8'h00, 1'b0, 3'b000, 1'b0);
    pop_bytes(2);

    // Reset with 3 committed and 2 tentative bytes in flight
    store_bytes(8'h21, 3);
    apply_stimulus(1'b0, 8'h00, 1'b0, 3'b101, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 3'b000, 1'b0);
    check_output("rst_mid_pre_occ", int'(bus.buffer_occupancy), 3);
    store_bytes(8'h31, 2);
    rst = 1'b1;
    apply_stimulus(1'b0, 8'h00, 1'b0, 3'b000, 1'b0);
    rst = 1'b0;
    check_output("rst_mid_occ", int'(bus.buffer_occupancy), 0);
    check_output("rst_mid_empty", int'(bus.buffer_empty), 1);
    check_output("rst_mid_full", int'(bus.buffer_full), 0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 3'b101, 1'b0);
    check_output("rst_mid_done_occ", int'(bus.buffer_occupancy), 0);
    check_output("rst_mid_done_empty", int'(bus.buffer_empty), 1);
    apply_stimulus(1'b0, 8'h00, 1'b0, 3'b000, 1'b0);

    apply_stimulus(1'b0, 8'h00, 1'b0, 3'b000, 1'b0);
    check_output("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/usb_rx_buffer.md
USB_RX_BUFFER -- requirements
Module: usb_rx_buffer

Interface
REQ-001 Parameter: DEPTH, default 64, byte capacity; SHALL be a power of two, 4..256.
REQ-002 Parameter: AW, default $clog2(DEPTH), pointer index width.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge only.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 rx_packet  in  3  receiver status from usb_rx; 3'b101 = DONE, 3'b110 = ERR, all other codes are "in packet/idle".
REQ-006 rx_packet_data  in  8  received byte from usb_rx.
REQ-007 store_rx_packet_data  in  1  one-cycle strobe: write rx_packet_data.
REQ-008 get_rx_data  in  1  pop strobe from the AHB-side consumer.
REQ-009 flush  in  1  discard all contents and clear error flags.
REQ-010 rx_data  out  8  head byte of committed data (first-word-fall-through).
REQ-011 buffer_occupancy  out  AW+1  count of committed, unread bytes.
REQ-012 buffer_empty  out  1  buffer_occupancy == 0.
REQ-013 buffer_full  out  1  write-side count (tentative + committed) == DEPTH.
REQ-014 overflow_err  out  1  sticky: a store was dropped.
REQ-015 underflow_err  out  1  sticky: a pop was issued while empty.

Function
REQ-016 Storage: DEPTH x 8 register array; pointers wr_ptr, cm_ptr (commit), rd_ptr, each AW+1 bits, wrap modulo 2*DEPTH; index = low AW bits.
REQ-017 Write: store_rx_packet_data=1 and buffer_full=0 -> mem[wr_ptr]=rx_packet_data, wr_ptr+1 next cycle; bytes between cm_ptr and wr_ptr are tentative and invisible to the reader.
REQ-018 Full store: store with buffer_full=1 -> byte dropped, wr_ptr unchanged, overflow_err=1, current packet marked bad (pkt_bad=1).
REQ-019 Edge detect: rx_packet registered to rx_packet_q; a DONE event is rx_packet==3'b101 && rx_packet_q!=3'b101; ERR event likewise for 3'b110.
REQ-020 Commit: DONE event with pkt_bad=0 -> cm_ptr <= effective wr_ptr (including any store in the same cycle); pkt_bad cleared.
REQ-021 Discard: ERR event, or DONE event with pkt_bad=1 -> wr_ptr <= cm_ptr (same-cycle store also discarded); pkt_bad cleared.
REQ-022 Holding DONE/ERR across multiple cycles SHALL produce exactly one commit/discard.
REQ-023 Read: get_rx_data=1 and buffer_empty=0 -> rd_ptr+1 next cycle; rx_data = mem[rd_ptr[AW-1:0]] combinationally, valid whenever buffer_empty=0.
REQ-024 Pop while empty -> no pointer change, underflow_err=1.
REQ-025 Simultaneous pop and store/commit: all act in the same cycle; occupancy = cm_ptr_next - rd_ptr_next.
REQ-026 buffer_occupancy = cm_ptr - rd_ptr (AW+1 bits, modular); buffer_full computed as wr_ptr - rd_ptr == DEPTH, so a pop frees space for the next-cycle store.
REQ-027 flush=1 -> all pointers 0, pkt_bad=0, overflow_err=0, underflow_err=0, rx_packet_q unchanged; flush overrides same-cycle store/pop/commit.
REQ-028 Error flags SHALL clear only on rst or flush.
REQ-029 Memory contents need not be reset; rx_data is don't-care while buffer_empty=1.

Reset
REQ-030 rst=1 at a clock edge -> wr_ptr=cm_ptr=rd_ptr=0, pkt_bad=0, rx_packet_q=3'b000, overflow_err=0, underflow_err=0; hence buffer_occupancy=0, buffer_empty=1, buffer_full=0.
REQ-031 rst asserted mid-packet SHALL discard tentative and committed data identically; rst has priority over flush and all other inputs.
REQ-032 Outputs SHALL be valid in the first cycle after rst deasserts; no startup latency.

Verification
REQ-033 Commit: store 0xA5,0x3C,0x0F, then rx_packet 3'b000->3'b101 -> occupancy 0 until DONE edge, 3 one cycle after; pops return A5,3C,0F; empty=1 after.
REQ-034 Discard: store 4 bytes, rx_packet -> 3'b110 -> occupancy stays 0, buffer_full=0, next packet of 2 bytes commits with occupancy=2 and correct data.
REQ-035 Overflow (DEPTH=64): store 65 bytes then DONE -> overflow_err=1, occupancy=0 (packet discarded); next 10-byte packet commits, occupancy=10.
REQ-036 Wrap: 3 rounds of 48-byte packets committed and fully drained, with pop and store in same cycles -> data order preserved across pointer wrap, occupancy never exceeds 48.
REQ-037 Underflow/flush: pop when empty -> underflow_err=1, pointers unchanged; flush with 5 committed bytes -> occupancy=0, both error flags 0 next cycle.
REQ-038 Reset mid-packet: 3 committed + 2 tentative bytes, assert rst one cycle -> occupancy=0, empty=1, following DONE edge commits nothing.
